ahb_sram_slave: RTL and testbench

//  AHB slave on one S_HSELX lane of the interconnect, fronting an on-chip word-addressed SRAM.

---
 rtl/ahb_sram_slave.sv | 168 ++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB slave fronting a word-addressed SRAM: programmable wait states, two-cycle ERROR, write-to-read forwarding.
// Optional AHB_SRAM_WSTRB_EN: write byte lanes taken from HWSTRB instead of HSIZE/address decode.
module ahb_sram_slave #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            HSEL,
    input  logic [AW-1:0]   HADDR,
    input  logic [1:0]      HTRANS,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic [DW/8-1:0] HWSTRB,
    input  logic [DW-1:0]   HWDATA,
    input  logic            HREADY_I,
    output logic [DW-1:0]   HRDATA,
    output logic            HREADY_O,
    output logic            HRESP
);
    localparam int NB   = DW / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IW   = AW - 4 - OFFW;
    localparam int MW   = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            hready_q, hready_d;
    logic            hresp_q, hresp_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            wr_pend_q, wr_pend_d;
    logic [MW-1:0]   wr_idx_q, wr_idx_d;
    logic [2:0]      wr_size_q, wr_size_d;
    logic [OFFW-1:0] wr_off_q, wr_off_d;

    logic [DW-1:0]   mem [DEPTH];

    logic            accept, a_err, commit;
    logic [IW-1:0]   a_idx;
    logic [MW-1:0]   a_midx;
    logic [NB-1:0]   size_lanes, wr_lanes;
    logic [DW-1:0]   read_val;
    logic            unused_ok;

    assign accept = HSEL & HTRANS[1] & HREADY_I;
    assign a_idx  = HADDR[AW-5:OFFW];
    assign a_midx = a_idx[MW-1:0];
    assign a_err  = (int'(a_idx) >= DEPTH) || (HSIZE > 3'(OFFW)) ||
                    ((HADDR[6:0] & ((7'd1 << HSIZE) - 7'd1)) != 7'd0);

    // A pending OKAY write lands in the SRAM on the cycle its data phase completes.
    assign commit = wr_pend_q & hready_q & ~hresp_q;

    always_comb begin
        size_lanes = '0;
        for (int b = 0; b < NB; b++)
            size_lanes[b] = (b >= int'(wr_off_q)) && (b < int'(wr_off_q) + (1 << wr_size_q));
    end

`ifdef AHB_SRAM_WSTRB_EN
    assign wr_lanes  = HWSTRB;
    assign unused_ok = ^{HADDR[AW-1:AW-4], HBURST, size_lanes};
`else
    assign wr_lanes  = size_lanes;
    assign unused_ok = ^{HADDR[AW-1:AW-4], HBURST, HWSTRB};
`endif

    // A read accepted alongside a completing write to the same word sees the merged bytes.
    always_comb begin
        read_val = mem[a_midx];
        for (int b = 0; b < NB; b++)
            if (commit && wr_lanes[b] && (wr_idx_q == a_midx))
                read_val[b*8 +: 8] = HWDATA[b*8 +: 8];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hready_d  = 1'b1;
        hresp_d   = 1'b0;
        rdata_d   = '0;
        wr_pend_d = wr_pend_q & ~commit;
        wr_idx_d  = wr_idx_q;
        wr_size_d = wr_size_q;
        wr_off_d  = wr_off_q;
        case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (a_err) begin
                        state_d  = S_ERR1;
                        hready_d = 1'b0;
                        hresp_d  = 1'b1;
                    end else begin
                        if (HWRITE) begin
                            wr_pend_d = 1'b1;
                            wr_idx_d  = a_midx;
                            wr_size_d = HSIZE;
                            wr_off_d  = HADDR[OFFW-1:0];
                        end else begin
                            rdata_d = read_val;
                        end
                        if (WAIT_STATES > 0) begin
                            state_d  = S_WAIT;
                            cnt_d    = 4'(WAIT_STATES - 1);
                            hready_d = 1'b0;
                        end
                    end
                end
            end
            S_WAIT: begin
                rdata_d = rdata_q;
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    hready_d = 1'b0;
                end
            end
            S_ERR1: begin
                state_d  = S_ERR2;
                hready_d = 1'b1;
                hresp_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hready_q  <= 1'b1;
            hresp_q   <= 1'b0;
            rdata_q   <= '0;
            wr_pend_q <= 1'b0;
            wr_idx_q  <= '0;
            wr_size_q <= 3'd0;
            wr_off_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
            rdata_q   <= rdata_d;
            wr_pend_q <= wr_pend_d;
            wr_idx_q  <= wr_idx_d;
            wr_size_q <= wr_size_d;
            wr_off_q  <= wr_off_d;
        end
    end

    always_ff @(posedge HCLK) begin
        for (int b = 0; b < NB; b++)
            if (commit && wr_lanes[b])
                mem[wr_idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
    end

    assign HRDATA   = rdata_q;
    assign HREADY_O = hready_q;
    assign HRESP    = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 2 wait states), transaction-level model with per-cycle response queue.
module tb_ahb_sram_slave;
    localparam int DEPTH = 1024;
    localparam int WS0   = 0;
    localparam int WS1   = 2;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } tr_t;

    typedef struct {
        logic        rdy;
        logic        resp;
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        hsel     [2];
    logic [31:0] haddr    [2];
    logic [1:0]  htrans   [2];
    logic        hwrite   [2];
    logic [2:0]  hsize    [2];
    logic [2:0]  hburst   [2];
    logic [3:0]  hwstrb   [2];
    logic [31:0] hwdata   [2];
    logic        hready_i [2];
    logic [31:0] hrdata   [2];
    logic        hready_o [2];
    logic        hresp    [2];

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    exp_t        eq [2][$];
    int          lows [2];
    int          ecyc [2];
    logic [31:0] last_rd [2];
    logic [31:0] mm [2][DEPTH];
    tr_t         seq [$];
    int          ws [2];
    int          run_cycles;
    int          l0, e0;

    assign hready_i[0] = hready_o[0];
    assign hready_i[1] = hready_o[1];

    ahb_sram_slave #(.AW(32), .DW(32), .DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWSTRB(hwstrb[0]),
        .HWDATA(hwdata[0]), .HREADY_I(hready_i[0]), .HRDATA(hrdata[0]),
        .HREADY_O(hready_o[0]), .HRESP(hresp[0]));

    ahb_sram_slave #(.AW(32), .DW(32), .DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWSTRB(hwstrb[1]),
        .HWDATA(hwdata[1]), .HREADY_I(hready_i[1]), .HRDATA(hrdata[1]),
        .HREADY_O(hready_o[1]), .HRESP(hresp[1]));

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic int m_idx(input tr_t t);
        return int'(t.addr[27:0]) / 4;
    endfunction

    function automatic bit m_err(input tr_t t);
        int bytes;
        bytes = 1 << t.size;
        return (m_idx(t) >= DEPTH) || (bytes > 4) || ((t.addr % bytes) != 0);
    endfunction

    function automatic logic [3:0] m_lanes(input tr_t t);
`ifdef AHB_SRAM_WSTRB_EN
        return t.strb;
`else
        return 4'(((1 << (1 << t.size)) - 1) << t.addr[1:0]);
`endif
    endfunction

    task automatic model_write(input int u, input tr_t t);
        logic [3:0] l;
        int idx;
        l   = m_lanes(t);
        idx = m_idx(t);
        for (int b = 0; b < 4; b++)
            if (l[b]) mm[u][idx][b*8 +: 8] = t.wdata[b*8 +: 8];
    endtask

    task automatic push_expect(input int u, input tr_t t);
        if (m_err(t)) begin
            eq[u].push_back('{rdy:1'b0, resp:1'b1, chk:1'b1, dat:32'h0});
            eq[u].push_back('{rdy:1'b1, resp:1'b1, chk:1'b1, dat:32'h0});
        end else begin
            for (int i = 0; i < ws[u]; i++)
                eq[u].push_back('{rdy:1'b0, resp:1'b0, chk:1'b0, dat:32'h0});
            eq[u].push_back('{rdy:1'b1, resp:1'b0, chk:!t.wr, dat:(t.wr ? 32'h0 : mm[u][m_idx(t)])});
        end
    endtask

    always @(negedge HCLK) begin
        exp_t e;
        for (int u = 0; u < 2; u++) begin
            if (mon_en) begin
                e = '{rdy:1'b1, resp:1'b0, chk:1'b0, dat:32'h0};
                if (eq[u].size() > 0) e = eq[u].pop_front();
                check($sformatf("u%0d_hready", u), {31'h0, hready_o[u]}, {31'h0, e.rdy});
                check($sformatf("u%0d_hresp", u), {31'h0, hresp[u]}, {31'h0, e.resp});
                if (e.chk) check($sformatf("u%0d_hrdata", u), hrdata[u], e.dat);
                if (hready_o[u] && !hresp[u] && e.chk) last_rd[u] = hrdata[u];
                if (!hready_o[u]) lows[u]++;
                if (hresp[u]) ecyc[u]++;
            end
        end
    end

    task automatic idle(input int u);
        hsel[u] = 1'b0; htrans[u] = 2'd0; hwrite[u] = 1'b0; hsize[u] = 3'd2;
        haddr[u] = 32'h0; hburst[u] = 3'd0; hwstrb[u] = 4'h0; hwdata[u] = 32'h0;
    endtask

    task automatic add(input logic sel, input logic [1:0] trans, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        tr_t t;
        t = '{sel:sel, trans:trans, wr:wr, size:size, addr:addr, wdata:wdata, strb:strb};
        seq.push_back(t);
    endtask

    // Pipelined driver: the next address phase is presented while the previous data phase runs.
    task automatic run(input int u);
        int  a = 0;
        int  stall = 0;
        bit  dv = 1'b0;
        bit  rdy;
        tr_t cur, dtr;
        run_cycles = 0;
        while (a < seq.size() || dv) begin
            if (a < seq.size()) begin
                cur = seq[a];
                hsel[u] = cur.sel; htrans[u] = cur.trans; hwrite[u] = cur.wr;
                hsize[u] = cur.size; haddr[u] = cur.addr; hburst[u] = 3'($urandom);
            end else begin
                hsel[u] = 1'b0; htrans[u] = 2'd0; hwrite[u] = 1'b0;
            end
            hwdata[u] = dv ? dtr.wdata : 32'h0;
            hwstrb[u] = dv ? dtr.strb : 4'h0;
            @(negedge HCLK);
            rdy = hready_o[u];
            @(posedge HCLK);
            #1;
            run_cycles++;
            if (rdy) begin
                stall = 0;
                if (dv && dtr.wr && !m_err(dtr)) model_write(u, dtr);
                dv = 1'b0;
                if (a < seq.size()) begin
                    if (cur.sel && cur.trans[1]) begin
                        dtr = cur;
                        dv  = 1'b1;
                        push_expect(u, cur);
                    end
                    a++;
                end
            end else begin
                stall++;
                if (stall > 64) begin
                    checks++;
                    errors++;
                    $display("FAIL run_timeout u%0d: HREADY_O low %0d cycles, required at most 64", u, stall);
                    break;
                end
            end
        end
        seq.delete();
        idle(u);
    endtask

    initial begin
        ws[0] = WS0;
        ws[1] = WS1;
        for (int u = 0; u < 2; u++) begin
            idle(u);
            lows[u] = 0;
            ecyc[u] = 0;
            last_rd[u] = 32'h0;
            for (int i = 0; i < DEPTH; i++) mm[u][i] = 32'h0;
        end

        #12;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset_hready_u%0d", u), {31'h0, hready_o[u]}, 32'h1);
            check($sformatf("reset_hresp_u%0d", u), {31'h0, hresp[u]}, 32'h0);
            check($sformatf("reset_hrdata_u%0d", u), hrdata[u], 32'h0);
        end
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        mon_en = 1'b1;

        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 32; i++)
                add(1'b1, 2'd2, 1'b1, 3'd2, 32'(i * 4), 32'hC0DE_0000 | 32'(i), 4'hF);
            run(u);
        end

        // Zero-wait write then read of the same word.
        l0 = lows[0];
        add(1'b1, 2'd2, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 4'hF);
        add(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 4'hF);
        run(0);
        check("t1_read_data", last_rd[0], 32'hDEAD_BEEF);
        check("t1_no_stall", 32'(lows[0] - l0), 32'd0);
        check("t1_cycles", 32'(run_cycles), 32'd3);

        // Two wait states on a single read.
        l0 = lows[1];
        add(1'b1, 2'd2, 1'b0, 3'd2, 32'h4, 32'h0, 4'hF);
        run(1);
        check("t2_wait_cycles", 32'(lows[1] - l0), 32'd2);
        check("t2_read_data", last_rd[1], 32'hC0DE_0001);
        check("t2_cycles", 32'(run_cycles), 32'd4);

        // Out-of-range index: two-cycle ERROR, word 0 (alias of the truncated index) untouched.
        e0 = ecyc[0];
        add(1'b1, 2'd2, 1'b0, 3'd2, 32'h1000, 32'h0, 4'hF);
        add(1'b1, 2'd2, 1'b1, 3'd2, 32'h1000, 32'hFFFF_FFFF, 4'hF);
        add(1'b1, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0, 4'hF);
        run(0);
        check("t3_err_cycles", 32'(ecyc[0] - e0), 32'd4);
        check("t3_sram_unchanged", last_rd[0], 32'hC0DE_0000);

        // Misaligned halfword write.
        e0 = ecyc[1];
        add(1'b1, 2'd2, 1'b1, 3'd1, 32'h3, 32'h1111_1111, 4'hF);
        add(1'b1, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0, 4'hF);
        run(1);
        check("t4_err_cycles", 32'(ecyc[1] - e0), 32'd2);
        check("t4_prior_data", last_rd[1], 32'hC0DE_0000);

        // INCR4 write burst followed by a read of the last beat.
        l0 = lows[0];
        for (int i = 0; i < 4; i++)
            add(1'b1, (i == 0) ? 2'd2 : 2'd3, 1'b1, 3'd2, 32'h20 + 32'(i * 4), 32'(i + 1), 4'hF);
        add(1'b1, 2'd2, 1'b0, 3'd2, 32'h2C, 32'h0, 4'hF);
        run(0);
        check("t5_forward_data", last_rd[0], 32'h4);
        check("t5_no_stall", 32'(lows[0] - l0), 32'd0);
        check("t5_cycles", 32'(run_cycles), 32'd6);
        check("t5_model_pin", mm[0][11], 32'h4);

`ifndef AHB_SRAM_WSTRB_EN
        // Sub-word writes: byte lane 2 of word 0, upper halfword of word 1.
        add(1'b1, 2'd2, 1'b1, 3'd0, 32'h2, 32'h00AB_0000, 4'h0);
        add(1'b1, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0, 4'hF);
        run(1);
        check("byte_lane2", last_rd[1], 32'hC0AB_0000);
        add(1'b1, 2'd2, 1'b1, 3'd1, 32'h6, 32'h7766_0000, 4'h0);
        add(1'b1, 2'd2, 1'b0, 3'd2, 32'h4, 32'h0, 4'hF);
        run(1);
        check("half_upper", last_rd[1], 32'h7766_0001);
`endif

        // Reset during the wait states of a write.
        mon_en = 1'b0;
        hsel[1] = 1'b1; htrans[1] = 2'd2; hwrite[1] = 1'b1; hsize[1] = 3'd2; haddr[1] = 32'h8;
        @(posedge HCLK);
        #1;
        hsel[1] = 1'b0; htrans[1] = 2'd0; hwrite[1] = 1'b0; hwdata[1] = 32'h1234_5678;
        @(negedge HCLK);
        check("t6_in_wait", {31'h0, hready_o[1]}, 32'h0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        #1;
        check("t6_rst_hready", {31'h0, hready_o[1]}, 32'h1);
        check("t6_rst_hresp", {31'h0, hresp[1]}, 32'h0);
        check("t6_rst_hrdata", hrdata[1], 32'h0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        idle(1);
        eq[0].delete();
        eq[1].delete();
        mon_en = 1'b1;
        add(1'b1, 2'd2, 1'b0, 3'd2, 32'h8, 32'h0, 4'hF);
        run(1);
        check("t6_word_kept", last_rd[1], 32'hC0DE_0002);

`ifdef AHB_SRAM_WSTRB_EN
        add(1'b1, 2'd2, 1'b1, 3'd2, 32'h0, 32'h0, 4'hF);
        add(1'b1, 2'd2, 1'b1, 3'd2, 32'h0, 32'hAABB_CCDD, 4'b0101);
        add(1'b1, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0, 4'hF);
        run(0);
        check("wstrb_merge", last_rd[0], 32'h00BB_00DD);
`endif

        // Randomized mix: reads/writes of all sizes, idle/busy/deselected slots, error addresses.
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 250; n++) begin
                int          r;
                logic [2:0]  sz;
                logic [31:0] ad;
                r  = int'($urandom_range(0, 9));
                sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                ad = {4'($urandom), 21'h0, 7'($urandom)};
                case (r)
                    0: add(1'b1, 2'd0, 1'b0, 3'd2, ad, 32'h0, 4'h0);
                    1: add(1'b1, 2'd1, 1'b1, 3'd2, ad, $urandom, 4'hF);
                    2: add(1'b0, 2'd2, 1'($urandom), 3'd2, ad, $urandom, 4'hF);
                    3: add(1'b1, 2'd2, 1'($urandom), 3'd2, 32'h1000 + 32'($urandom_range(0, 63) * 4),
                           $urandom, 4'($urandom));
                    default: add(1'b1, 2'($urandom_range(2, 3)), 1'($urandom), sz, ad, $urandom, 4'($urandom));
                endcase
            end
            run(u);
        end

        repeat (3) @(posedge HCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
